// File: rtl/mux_arb_n.sv
// N-input registered multiplexer with per-lane valid/ready handshakes.
// Supports fixed-select and round-robin arbitration. The output register adds one stage and can drain and reload in the same cycle.
module mux_arb_n #(
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = 2,
    localparam int NUM_IN   = 2 ** SEL_WIDTH
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] MuxIn,
    input  logic [NUM_IN-1:0]       InValid,
    output logic [NUM_IN-1:0]       InReady,
    input  logic [SEL_WIDTH-1:0]    Select,
    input  logic                    Mode,
    output logic [WIDTH-1:0]        MuxOut,
    output logic [SEL_WIDTH-1:0]    OutSel,
    output logic                    OutValid,
    input  logic                    OutReady
);

    logic [WIDTH-1:0]     lane [NUM_IN];
    logic [SEL_WIDTH-1:0] rr_idx [NUM_IN];
    logic [NUM_IN-1:0]    rot_valid;
    logic [SEL_WIDTH-1:0] rr_off;
    logic [SEL_WIDTH-1:0] rr_cand;

    logic [SEL_WIDTH-1:0] cand;
    logic                 grant_valid;
    logic                 load_en;
    logic                 take;

    logic [WIDTH-1:0]     out_data_reg, out_data_next;
    logic [SEL_WIDTH-1:0] out_sel_reg, out_sel_next;
    logic                 out_valid_reg, out_valid_next;
    logic [SEL_WIDTH-1:0] ptr_reg, ptr_next;

    // Unpack lanes and view the valid vector rotated so that the pointer lane sits at offset 0.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
            assign lane[gi]      = MuxIn[gi*WIDTH +: WIDTH];
            assign rr_idx[gi]    = ptr_reg + SEL_WIDTH'(gi);
            assign rot_valid[gi] = InValid[rr_idx[gi]];
        end
    endgenerate

    // Lowest set offset in the rotated view is the first valid lane at or after the pointer.
    always_comb begin
        rr_off = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                rr_off = SEL_WIDTH'(k);
            end
        end
    end

    assign rr_cand = ptr_reg + rr_off;

    always_comb begin
        if (Mode) begin
            cand        = rr_cand;
            grant_valid = |InValid;
        end else begin
            cand        = Select;
            grant_valid = InValid[Select];
        end
    end

    assign load_en = !out_valid_reg || OutReady;
    assign take    = load_en && grant_valid && !Reset;
    assign InReady = take ? (NUM_IN'(1) << cand) : '0;

    always_comb begin
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        out_valid_next = out_valid_reg;
        ptr_next       = ptr_reg;
        if (load_en) begin
            if (grant_valid) begin
                out_data_next  = lane[cand];
                out_sel_next   = cand;
                out_valid_next = 1'b1;
                if (Mode) begin
                    ptr_next = cand + SEL_WIDTH'(1);
                end
            end else begin
                // Empty slot: data and lane index keep their last values.
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            out_valid_reg <= out_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign MuxOut   = out_data_reg;
    assign OutSel   = out_sel_reg;
    assign OutValid = out_valid_reg;

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench for mux_arb_n: a cycle model derived from the arbitration rules plus directed literal checks.
module tb_mux_arb_n;

    localparam int WIDTH     = 32;
    localparam int SEL_WIDTH = 2;
    localparam int N         = 4;

    logic                   Clk = 1'b0;
    logic                   Reset = 1'b1;
    logic [N*WIDTH-1:0]     MuxIn = '0;
    logic [N-1:0]           InValid = '0;
    logic [N-1:0]           InReady;
    logic [SEL_WIDTH-1:0]   Select = '0;
    logic                   Mode = 1'b0;
    logic [WIDTH-1:0]       MuxOut;
    logic [SEL_WIDTH-1:0]   OutSel;
    logic                   OutValid;
    logic                   OutReady = 1'b0;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    // Model state
    logic                 m_valid = 1'b0;
    logic [WIDTH-1:0]     m_data  = '0;
    logic [SEL_WIDTH-1:0] m_sel   = '0;
    int                   m_ptr   = 0;

    mux_arb_n #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) dut (
        .Clk(Clk), .Reset(Reset), .MuxIn(MuxIn), .InValid(InValid),
        .InReady(InReady), .Select(Select), .Mode(Mode), .MuxOut(MuxOut),
        .OutSel(OutSel), .OutValid(OutValid), .OutReady(OutReady)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane granted this cycle according to the arbitration rules, or -1.
    function automatic int model_grant();
        int idx;
        if (Reset) return -1;
        if (m_valid && !OutReady) return -1;
        if (!Mode) return InValid[Select] ? int'(Select) : -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (InValid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = model_grant();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
            m_ptr   <= 0;
        end else if (!m_valid || OutReady) begin
            if (model_grant() >= 0) begin
                m_data  <= MuxIn[model_grant()*WIDTH +: WIDTH];
                m_sel   <= SEL_WIDTH'(model_grant());
                m_valid <= 1'b1;
                if (Mode) m_ptr <= (model_grant() + 1) % N;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (!done) begin
            chk("in_ready", InReady, exp_ready());
            chk("out_valid", OutValid, m_valid);
            chk("mux_out", MuxOut, m_data);
            chk("out_sel", OutSel, m_sel);
            if (OutValid && OutReady)
                $display("xfer sel=%0d data=%08h t=%0t", OutSel, MuxOut, $time);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
        MuxIn[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [SEL_WIDTH-1:0] rr_seq1 [5];
        logic [SEL_WIDTH-1:0] rr_seq2 [4];
        rr_seq1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_seq2 = '{2'd3, 2'd0, 2'd3, 2'd0};
        for (int i = 0; i < N; i++) set_lane(i, 32'hA000_0000 + i);

        // Reset held for two edges
        step();
        step();
        chk("rst_ready", InReady, 4'b0000);
        Reset = 1'b0;
        #1;
        chk("rst_valid", OutValid, 1'b0);
        chk("rst_out", MuxOut, 32'h0);

        // Fixed select
        Mode = 1'b0; Select = 2'd2; InValid = 4'b1111; OutReady = 1'b1;
        set_lane(2, 32'hDEADBEEF);
        #1;
        chk("fix_ready", InReady, 4'b0100);
        step();
        chk("fix_out", MuxOut, 32'hDEADBEEF);
        chk("fix_sel", OutSel, 2'd2);
        chk("fix_valid", OutValid, 1'b1);

        // Fixed select on an idle lane
        Select = 2'd1; InValid = 4'b1101;
        #1;
        chk("fix_inv_ready", InReady, 4'b0000);
        step();
        chk("fix_inv_valid", OutValid, 1'b0);
        chk("fix_inv_hold", MuxOut, 32'hDEADBEEF);

        // Round-robin fairness
        Mode = 1'b1; InValid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_all_sel", OutSel, rr_seq1[i]);
        end
        InValid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_pair_sel", OutSel, rr_seq2[i]);
        end

        // Backpressure with lane 1 held
        InValid = 4'b1111;
        set_lane(1, 32'h1111_1111);
        step();
        chk("bp_load_sel", OutSel, 2'd1);
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            InValid = N'($urandom);
            Select  = SEL_WIDTH'($urandom);
            Mode    = 1'($urandom);
            MuxIn   = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("bp_ready", InReady, 4'b0000);
            step();
            chk("bp_sel", OutSel, 2'd1);
            chk("bp_out", MuxOut, 32'h1111_1111);
            chk("bp_valid", OutValid, 1'b1);
        end
        Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b1;
        #1;
        chk("bp_release_ready", InReady, 4'b0100);
        step();
        chk("bp_release_sel", OutSel, 2'd2);

        // Mode switch preserves the round-robin pointer
        InValid = 4'b0010;
        step();
        chk("ms_sel1", OutSel, 2'd1);
        Mode = 1'b0; Select = 2'd0; InValid = 4'b1111;
        step();
        chk("ms_fix0", OutSel, 2'd0);
        step();
        chk("ms_fix1", OutSel, 2'd0);
        Mode = 1'b1;
        #1;
        chk("ms_rr_ready", InReady, 4'b0100);
        step();
        chk("ms_rr_sel", OutSel, 2'd2);

        // Asynchronous reset mid-stream
        #1;
        Reset = 1'b1;
        #1;
        chk("ar_valid", OutValid, 1'b0);
        chk("ar_out", MuxOut, 32'h0);
        chk("ar_sel", OutSel, 2'd0);
        chk("ar_ready", InReady, 4'b0000);
        step();
        Reset = 1'b0;
        Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b1;
        #1;
        chk("ar_first_ready", InReady, 4'b0001);
        step();
        chk("ar_first_sel", OutSel, 2'd0);
        chk("ar_first_valid", OutValid, 1'b1);

        // Random traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            InValid  = N'($urandom);
            Select   = SEL_WIDTH'($urandom);
            Mode     = 1'($urandom);
            OutReady = ($urandom_range(0, 3) != 0);
            MuxIn    = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        // Drain to empty
        InValid = '0; OutReady = 1'b1;
        step();
        chk("drain_valid", OutValid, 1'b0);

        @(negedge Clk);
        #1;
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
